// File: rtl/fxp_pkg.sv
// Shared fixed-point constants and helpers for the recursive-gaussian datapath.
// Includes the round-robin priority search reused by the operator-sharing blocks.
package fxp_pkg;

    localparam int unsigned FXP_N  = 16;
    localparam int unsigned FXP_Q  = 12;
    localparam int unsigned RR_MAX = 8;

    // Magnitude field of an n-bit sign-magnitude word, zero-extended.
    function automatic logic [63:0] sm_mag(input logic [63:0] x, input int unsigned n);
        logic [63:0] mask;
        mask = (64'd1 << (n - 1)) - 64'd1;
        return x & mask;
    endfunction

    function automatic logic sm_sign(input logic [63:0] x, input int unsigned n);
        return ((x >> (n - 1)) & 64'd1) != 64'd0;
    endfunction

    // One-hot grant for the first set bit of req, searching circularly from start.
    function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req,
                                                  input int unsigned start,
                                                  input int unsigned nreq);
        logic [RR_MAX-1:0] grant;
        logic              found;
        int unsigned       idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < RR_MAX; i++) begin
            idx = start + i;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if (!found && (i < nreq) && (((req >> idx) & RR_MAX'(1)) != '0)) begin
                grant = RR_MAX'(1) << idx;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fxp_sm_mul.sv
// Combinational sign-magnitude Q-format multiply: truncates the low Q bits,
// flags overflow without saturating.
module fxp_sm_mul
    import fxp_pkg::*;
#(
    parameter int unsigned N = FXP_N,
    parameter int unsigned Q = FXP_Q
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-2:0] mag,
    output logic         sign,
    output logic         ovr
);

    localparam int unsigned W = 2 * N;

    logic [W-1:0] a_mag;
    logic [W-1:0] b_mag;
    logic [W-1:0] prod;
    logic [W-1:0] scaled;

    always_comb begin
        a_mag  = W'(sm_mag(64'(a), N));
        b_mag  = W'(sm_mag(64'(b), N));
        prod   = a_mag * b_mag;
        scaled = prod >> Q;
        mag    = scaled[N-2:0];
        // Anything left above the magnitude field after scaling is lost range.
        ovr    = |scaled[W-1:N-1];
        sign   = sm_sign(64'(a), N) ^ sm_sign(64'(b), N);
    end

endmodule

// File: rtl/fxp_mul_rr_arbiter.sv
// Round-robin arbiter sharing one sign-magnitude multiplier between NREQ requesters,
// with a two-stage pipeline, one-hot result tags and per-requester sticky overflow.
module fxp_mul_rr_arbiter
    import fxp_pkg::*;
#(
    parameter int unsigned N    = FXP_N,
    parameter int unsigned Q    = FXP_Q,
    parameter int unsigned NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   i_valid,
    input  logic [NREQ*N-1:0] i_a,
    input  logic [NREQ*N-1:0] i_b,
    output logic [NREQ-1:0]   o_ready,
    output logic [NREQ-1:0]   o_rvalid,
    output logic [N-1:0]      o_result,
    output logic              o_ovr,
    output logic [NREQ-1:0]   o_ovr_sticky,
    input  logic [NREQ-1:0]   i_ovr_clr
);

    localparam int unsigned PtrW = $clog2(NREQ);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            xfer;
    logic [N-1:0]    sel_a, sel_b;

    logic [N-1:0]    s1_a_q, s1_b_q;
    logic [NREQ-1:0] s1_tag_q;
    logic            s1_v_q;

    logic [N-2:0]    mul_mag;
    logic            mul_sign, mul_ovr;

    logic [NREQ-1:0] rvalid_q;
    logic [N-1:0]    result_q;
    logic            ovr_q;
    logic [NREQ-1:0] sticky_q, sticky_d;

    // Grant is always a subset of i_valid, so any grant bit is a transfer.
    always_comb begin
        o_ready = NREQ'(rr_pick(RR_MAX'(i_valid), 32'(ptr_q), NREQ));
        xfer    = |o_ready;
    end

    always_comb begin
        ptr_d = ptr_q;
        sel_a = '0;
        sel_b = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (o_ready[k]) begin
                sel_a = i_a[k*N +: N];
                sel_b = i_b[k*N +: N];
                ptr_d = (k == NREQ - 1) ? '0 : PtrW'(k + 1);
            end
        end
    end

    fxp_sm_mul #(
        .N(N),
        .Q(Q)
    ) u_mul (
        .a   (s1_a_q),
        .b   (s1_b_q),
        .mag (mul_mag),
        .sign(mul_sign),
        .ovr (mul_ovr)
    );

    // Set wins over a same-cycle clear.
    always_comb begin
        sticky_d = (sticky_q & ~i_ovr_clr) | ((s1_v_q && mul_ovr) ? s1_tag_q : '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            s1_v_q   <= 1'b0;
            s1_a_q   <= '0;
            s1_b_q   <= '0;
            s1_tag_q <= '0;
            rvalid_q <= '0;
            result_q <= '0;
            ovr_q    <= 1'b0;
            sticky_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            s1_v_q   <= xfer;
            if (xfer) begin
                s1_a_q   <= sel_a;
                s1_b_q   <= sel_b;
                s1_tag_q <= o_ready;
            end
            rvalid_q <= s1_v_q ? s1_tag_q : '0;
            if (s1_v_q) begin
                result_q <= {mul_sign, mul_mag};
                ovr_q    <= mul_ovr;
            end
            sticky_q <= sticky_d;
        end
    end

    assign o_rvalid     = rvalid_q;
    assign o_result     = result_q;
    assign o_ovr        = ovr_q;
    assign o_ovr_sticky = sticky_q;

endmodule

// File: tb/tb_fxp_mul_rr_arbiter.sv
// Self-checking bench for fxp_mul_rr_arbiter: directed vectors, arbitration
// sequences, reset mid-flight and randomized traffic against a behavioural model.
module tb_fxp_mul_rr_arbiter;

    localparam int N    = 16;
    localparam int Q    = 12;
    localparam int NREQ = 4;

    logic              clk;
    logic              rst;
    logic [NREQ-1:0]   i_valid;
    logic [NREQ*N-1:0] i_a;
    logic [NREQ*N-1:0] i_b;
    logic [NREQ-1:0]   o_ready;
    logic [NREQ-1:0]   o_rvalid;
    logic [N-1:0]      o_result;
    logic              o_ovr;
    logic [NREQ-1:0]   o_ovr_sticky;
    logic [NREQ-1:0]   i_ovr_clr;

    fxp_mul_rr_arbiter #(
        .N   (N),
        .Q   (Q),
        .NREQ(NREQ)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_ready     (o_ready),
        .o_rvalid    (o_rvalid),
        .o_result    (o_result),
        .o_ovr       (o_ovr),
        .o_ovr_sticky(o_ovr_sticky),
        .i_ovr_clr   (i_ovr_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int              due;
        logic [NREQ-1:0] tag;
        logic [N-1:0]    res;
        logic            ovr;
    } exp_t;

    typedef struct {
        int           req;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] res;
        logic         ovr;
    } vec_t;

    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    int              ptr_m  = 0;
    logic [NREQ-1:0] sticky_m;
    exp_t            expq[$];
    int              grant_log[$];
    logic [NREQ-1:0] rvalid_log[$];
    logic [NREQ-1:0] cap_rvalid;
    logic [N-1:0]    cap_result;
    logic            cap_ovr;
    logic [NREQ-1:0] last_ready;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Circular search from p for the first valid requester.
    function automatic int rr_model(input logic [NREQ-1:0] v, input int p);
        for (int off = 0; off < NREQ; off++) begin
            int k;
            k = (p + off) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic void mul_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                      output logic [N-1:0] res, output logic ovr);
        longint unsigned am, bm, sh;
        am  = 64'(a[N-2:0]);
        bm  = 64'(b[N-2:0]);
        sh  = (am * bm) >> Q;
        ovr = (sh >> (N - 1)) != 0;
        res = N'(sh % (64'd1 << (N - 1)));
        res[N-1] = a[N-1] ^ b[N-1];
    endfunction

    task automatic run_cycle(input logic [NREQ-1:0] v, input logic [NREQ*N-1:0] a,
                             input logic [NREQ*N-1:0] b, input logic [NREQ-1:0] clr,
                             output int g);
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] set;
        exp_t            e;
        i_valid   = v;
        i_a       = a;
        i_b       = b;
        i_ovr_clr = clr;
        g  = rr_model(v, ptr_m);
        eg = (g >= 0) ? (NREQ'(1) << g) : '0;
        @(negedge clk);
        chk("ready", 32'(o_ready), 32'(eg));
        last_ready = o_ready;
        grant_log.push_back(g);
        rvalid_log.push_back(o_rvalid);
        if (o_rvalid != '0) begin
            cap_rvalid = o_rvalid;
            cap_result = o_result;
            cap_ovr    = o_ovr;
        end
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk("rvalid_tag", 32'(o_rvalid), 32'(expq[0].tag));
            chk("result", 32'(o_result), 32'(expq[0].res));
            chk("ovr", 32'(o_ovr), 32'(expq[0].ovr));
            void'(expq.pop_front());
        end else begin
            chk("rvalid_idle", 32'(o_rvalid), 32'(0));
        end
        chk("sticky", 32'(o_ovr_sticky), 32'(sticky_m));
        @(posedge clk);
        set = '0;
        if (expq.size() > 0 && expq[0].due == cyc + 1 && expq[0].ovr) set = expq[0].tag;
        sticky_m = (sticky_m & ~clr) | set;
        if (g >= 0) begin
            e.due = cyc + 2;
            e.tag = eg;
            mul_model(a[g*N +: N], b[g*N +: N], e.res, e.ovr);
            expq.push_back(e);
            ptr_m = (g + 1) % NREQ;
        end
        cyc++;
        #1;
    endtask

    task automatic do_reset(input logic [NREQ-1:0] v);
        int g;
        i_valid   = v;
        i_a       = '0;
        i_b       = '0;
        i_ovr_clr = '0;
        rst       = 1'b1;
        expq.delete();
        ptr_m    = 0;
        sticky_m = '0;
        g = rr_model(v, 0);
        @(negedge clk);
        chk("rst_rvalid", 32'(o_rvalid), 32'(0));
        chk("rst_result", 32'(o_result), 32'(0));
        chk("rst_ovr", 32'(o_ovr), 32'(0));
        chk("rst_sticky", 32'(o_ovr_sticky), 32'(0));
        chk("rst_ready", 32'(o_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        i_valid = '0;
        @(posedge clk);
        #1;
    endtask

    vec_t              vecs[6];
    int                exp_resume[6];
    logic [NREQ*N-1:0] abus, bbus, ra, rb;
    logic [NREQ-1:0]   pend, clr;
    int                g;

    initial begin
        vecs[0] = '{0, 16'h1800, 16'h2000, 16'h3000, 1'b0};
        vecs[1] = '{2, 16'h9000, 16'h1800, 16'h9800, 1'b0};
        vecs[2] = '{2, 16'h8000, 16'h1000, 16'h8000, 1'b0};
        vecs[3] = '{3, 16'h0800, 16'h0800, 16'h0400, 1'b0};
        vecs[4] = '{3, 16'h8001, 16'h0001, 16'h8000, 1'b0};
        vecs[5] = '{1, 16'h7FFF, 16'h7FFF, 16'h7FF0, 1'b1};
        exp_resume = '{2, 2, 2, 3, 0, 1};

        rst       = 1'b1;
        i_valid   = '0;
        i_a       = '0;
        i_b       = '0;
        i_ovr_clr = '0;
        sticky_m  = '0;
        #1;
        do_reset(4'b0100);

        // Directed single-transfer vectors.
        for (int i = 0; i < 6; i++) begin
            abus = '0;
            bbus = '0;
            abus[vecs[i].req*N +: N] = vecs[i].a;
            bbus[vecs[i].req*N +: N] = vecs[i].b;
            cap_rvalid = '0;
            cap_result = '0;
            cap_ovr    = 1'b0;
            run_cycle(NREQ'(1) << vecs[i].req, abus, bbus, '0, g);
            run_cycle('0, '0, '0, '0, g);
            run_cycle('0, '0, '0, '0, g);
            chk("vec_tag", 32'(cap_rvalid), 32'd1 << vecs[i].req);
            chk("vec_result", 32'(cap_result), 32'(vecs[i].res));
            chk("vec_ovr", 32'(cap_ovr), 32'(vecs[i].ovr));
        end
        chk("sticky_after_ovr", 32'(o_ovr_sticky), 32'h2);

        // Clear, then overflow and clear landing in the same cycle.
        run_cycle('0, '0, '0, 4'b0010, g);
        chk("sticky_cleared", 32'(o_ovr_sticky), 32'h0);
        abus = '0;
        bbus = '0;
        abus[1*N +: N] = 16'h7FFF;
        bbus[1*N +: N] = 16'h7FFF;
        run_cycle(4'b0010, abus, bbus, '0, g);
        run_cycle('0, '0, '0, 4'b0010, g);
        chk("sticky_set_wins", 32'(o_ovr_sticky), 32'h2);
        run_cycle('0, '0, '0, '0, g);

        // Fairness with all requesters valid.
        do_reset('0);
        for (int k = 0; k < NREQ; k++) begin
            abus[k*N +: N] = N'($urandom);
            bbus[k*N +: N] = N'($urandom);
        end
        grant_log.delete();
        rvalid_log.delete();
        for (int i = 0; i < 8; i++) run_cycle(4'b1111, abus, bbus, '0, g);
        run_cycle('0, '0, '0, '0, g);
        run_cycle('0, '0, '0, '0, g);
        for (int i = 0; i < 8; i++) begin
            chk("fair_grant", 32'(grant_log[i]), 32'(i % NREQ));
            chk("fair_rvalid", 32'(rvalid_log[i+2]), 32'd1 << (i % NREQ));
        end

        // Pointer resumes after a lone requester.
        grant_log.delete();
        for (int i = 0; i < 3; i++) run_cycle(4'b0100, abus, bbus, '0, g);
        for (int i = 0; i < 3; i++) run_cycle(4'b1111, abus, bbus, '0, g);
        for (int i = 0; i < 6; i++) chk("resume_grant", 32'(grant_log[i]), 32'(exp_resume[i]));
        run_cycle('0, '0, '0, '0, g);
        run_cycle('0, '0, '0, '0, g);

        // Reset asserted one cycle after an overflowing transfer.
        abus = '0;
        bbus = '0;
        abus[1*N +: N] = 16'h7FFF;
        bbus[1*N +: N] = 16'h7FFF;
        run_cycle(4'b0010, abus, bbus, '0, g);
        i_valid = '0;
        #2;
        rst = 1'b1;
        expq.delete();
        ptr_m    = 0;
        sticky_m = '0;
        @(negedge clk);
        chk("mid_rst_rvalid", 32'(o_rvalid), 32'(0));
        @(posedge clk);
        #1;
        chk("mid_rst_rvalid2", 32'(o_rvalid), 32'(0));
        chk("mid_rst_sticky", 32'(o_ovr_sticky), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            abus[k*N +: N] = N'($urandom);
            bbus[k*N +: N] = N'($urandom);
        end
        run_cycle(4'b1111, abus, bbus, '0, g);
        chk("restart_grant", 32'(last_ready), 32'h1);
        run_cycle('0, '0, '0, '0, g);
        run_cycle('0, '0, '0, '0, g);

        // Randomized traffic obeying the hold-until-granted rule, with occasional drops.
        pend = '0;
        ra   = '0;
        rb   = '0;
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]      = 1'b1;
                    ra[k*N +: N] = N'($urandom);
                    rb[k*N +: N] = ($urandom_range(0, 1) == 0) ? N'($urandom) :
                                                                 N'($urandom_range(0, 16'h1FFF));
                end else if (pend[k] && $urandom_range(0, 31) == 0) begin
                    pend[k] = 1'b0;
                end
            end
            clr = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
            run_cycle(pend, ra, rb, clr, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        for (int i = 0; i < 3; i++) run_cycle('0, '0, '0, '0, g);
        chk("queue_drained", 32'(expq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
